mem_lsu: RTL and testbench

Load/store unit forming the MEM stage directly downstream of EX. Consumes the EX ALU result as the effective address and register2 as store data, runs a req/ack transaction on a 32-bit word-addressed data bus with byte enables, and returns sign- or zero-extended load data to writeback. Stalls the upstream pipeline while a bus transaction is outstanding and reports misaligned, illegal-size and timed-out accesses.

---
 rtl/mem_lsu.sv | 248 ++++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu -- MEM-stage load/store unit.
//
// Takes the EX ALU result as the effective byte address and register2 as
// store data. Runs one req/ack transaction per legal access on a 32-bit
// word-addressed bus with byte enables, then returns sign- or zero-extended
// load data to writeback. The upstream pipeline is held while a transaction
// is outstanding. Misaligned or illegal-size accesses and bus timeouts are
// reported alongside o_valid.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_valid               EX holds a valid instruction this cycle
//   i_MemRead/i_MemWrite  load / store (load wins when both are set)
//   i_funct3              size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   i_ALUResult           effective byte address
//   i_register2           store data
//   o_stall               upstream holds its pipeline register
//   o_valid               one-cycle completion pulse
//   o_ReadData            extended load data (0 for stores/non-mem/errors)
//   o_misaligned, o_fault error flags, qualified by o_valid
//   o_mem_*               bus request side (word address, byte enables)
//   i_mem_ack, i_mem_rdata bus response side
module mem_lsu #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_ALUResult,
    input  logic [31:0] i_register2,
    output logic        o_stall,
    output logic        o_valid,
    output logic [31:0] o_ReadData,
    output logic        o_misaligned,
    output logic        o_fault,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Counter value seen in the last BUSY cycle before the access is aborted.
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_next;

    // Request decode (current EX instruction)
    logic        is_load;
    logic        is_store;
    logic        is_access;
    logic        funct3_ok;
    logic        aligned;
    logic        accept;
    logic        quick_done;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;

    // Latched transaction
    logic [29:0] word_q;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [7:0]  wait_cnt;

    // Completion
    logic        ack_hit;
    logic        timeout;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic        valid_q;
    logic        misaligned_q;
    logic        fault_q;
    logic [31:0] read_data_q;

    // ------------------------------------------------------------------
    // Decode of the instruction presented by EX
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        is_load    = i_MemRead;
        is_store   = i_MemWrite && !i_MemRead;
        is_access  = is_load || is_store;

        funct3_ok  = 1'b0;
        case (i_funct3)
            F3_B, F3_H, F3_W: funct3_ok = 1'b1;
            F3_BU, F3_HU:     funct3_ok = is_load;  // unsigned sizes are load-only
            default:          funct3_ok = 1'b0;
        endcase

        // Byte-size defaults; H and W override below.
        aligned    = 1'b1;
        be_calc    = 4'b0001 << i_ALUResult[1:0];
        wdata_calc = {4{i_register2[7:0]}};
        case (i_funct3[1:0])
            2'b01: begin
                aligned    = !i_ALUResult[0];
                be_calc    = i_ALUResult[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{i_register2[15:0]}};
            end
            2'b10: begin
                aligned    = (i_ALUResult[1:0] == 2'b00);
                be_calc    = 4'b1111;
                wdata_calc = i_register2;
            end
            default: ;
        endcase

        accept     = (state == IDLE) && i_valid && is_access && funct3_ok && aligned;
        // Non-memory ops and rejected accesses finish without touching the bus.
        quick_done = (state == IDLE) && i_valid && !accept;
    end

    assign ack_hit = (state == BUSY) && i_mem_ack;
    // An ack arriving in the final wait cycle still wins over the timeout.
    assign timeout = (state == BUSY) && !i_mem_ack && (wait_cnt == LAST_WAIT);

    // ------------------------------------------------------------------
    // Load data lane selection and extension
    // ------------------------------------------------------------------
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = i_mem_rdata[7:0];
            2'd1:    byte_sel = i_mem_rdata[15:8];
            2'd2:    byte_sel = i_mem_rdata[23:16];
            default: byte_sel = i_mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

        case (funct3_q)
            F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_ext = {24'd0, byte_sel};
            F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_ext = {16'd0, half_sel};
            F3_W:    load_ext = i_mem_rdata;
            default: load_ext = 32'd0;
        endcase
        if (we_q) begin
            load_ext = 32'd0;  // stores return nothing to writeback
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (ack_hit || timeout) state_next = DONE;
            DONE:    state_next = IDLE;  // no acceptance: EX still shows the finished op
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the latched transaction is reset too, because every
            // output (including the bus fields) must read 0 after reset.
            state        <= IDLE;
            word_q       <= '0;
            lane_q       <= '0;
            funct3_q     <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            wait_cnt     <= '0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
            read_data_q  <= '0;
        end else begin
            state   <= state_next;
            valid_q <= quick_done || ack_hit || timeout;

            if (accept) begin
                word_q   <= i_ALUResult[31:2];
                lane_q   <= i_ALUResult[1:0];
                funct3_q <= i_funct3;
                we_q     <= is_store;
                be_q     <= be_calc;
                wdata_q  <= wdata_calc;
                wait_cnt <= '0;
            end else if (state == BUSY) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            // Result fields only change on a completion, so they hold
            // their value until the next o_valid.
            if (quick_done) begin
                read_data_q  <= '0;
                misaligned_q <= is_access;
                fault_q      <= 1'b0;
            end else if (ack_hit) begin
                read_data_q  <= load_ext;
                misaligned_q <= 1'b0;
                fault_q      <= 1'b0;
            end else if (timeout) begin
                read_data_q  <= '0;
                misaligned_q <= 1'b0;
                fault_q      <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_stall      = accept || (state == BUSY);
    assign o_valid      = valid_q;
    assign o_ReadData   = read_data_q;
    assign o_misaligned = misaligned_q;
    assign o_fault      = fault_q;
    assign o_mem_req    = (state == BUSY);
    assign o_mem_we     = we_q;
    assign o_mem_addr   = {word_q, 2'b00};
    assign o_mem_wdata  = wdata_q;
    assign o_mem_be     = be_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu. Inputs are driven 2 time units after each
// rising edge and outputs are sampled 1 unit later, well away from the edge.
module tb_mem_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        i_MemRead;
    logic        i_MemWrite;
    logic [2:0]  i_funct3;
    logic [31:0] i_ALUResult;
    logic [31:0] i_register2;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_ReadData;
    logic        o_misaligned;
    logic        o_fault;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int req_cycles;
    bit seen_valid;

    mem_lsu #(.MAX_WAIT(15)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_MemRead    (i_MemRead),
        .i_MemWrite   (i_MemWrite),
        .i_funct3     (i_funct3),
        .i_ALUResult  (i_ALUResult),
        .i_register2  (i_register2),
        .o_stall      (o_stall),
        .o_valid      (o_valid),
        .o_ReadData   (o_ReadData),
        .o_misaligned (o_misaligned),
        .o_fault      (o_fault),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_be     (o_mem_be),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2);
        i_valid     = v;
        i_MemRead   = rd;
        i_MemWrite  = wr;
        i_funct3    = f3;
        i_ALUResult = addr;
        i_register2 = rs2;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    // Advance to 2 units after the next rising edge (the drive point).
    task automatic next_cycle();
        @(posedge i_clk);
        #2;
    endtask

    // Zero-wait legal access: accept, req+ack, o_valid, back to idle.
    task automatic do_access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_rd);
        drive(1'b1, rd, wr, f3, addr, rs2);
        #1;
        check({tag, " accept_stall"}, o_stall, 1);
        check({tag, " accept_req"}, o_mem_req, 0);
        next_cycle();
        i_mem_ack   = 1'b1;
        i_mem_rdata = rdata;
        #1;
        check({tag, " busy_req"}, o_mem_req, 1);
        check({tag, " busy_stall"}, o_stall, 1);
        check({tag, " busy_we"}, o_mem_we, wr);
        check({tag, " busy_addr"}, o_mem_addr, exp_addr);
        check({tag, " busy_be"}, o_mem_be, exp_be);
        if (wr) check({tag, " busy_wdata"}, o_mem_wdata, exp_wdata);
        check({tag, " busy_valid"}, o_valid, 0);
        next_cycle();
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'd0;
        #1;
        check({tag, " done_valid"}, o_valid, 1);
        check({tag, " done_stall"}, o_stall, 0);
        check({tag, " done_req"}, o_mem_req, 0);
        check({tag, " done_rdata"}, o_ReadData, exp_rd);
        check({tag, " done_mis"}, o_misaligned, 0);
        check({tag, " done_fault"}, o_fault, 0);
        next_cycle();
        drive_idle();
        #1;
        check({tag, " after_valid"}, o_valid, 0);
    endtask

    // Op that completes without the bus (non-memory or rejected access).
    task automatic quick_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic exp_mis);
        drive(1'b1, rd, wr, f3, addr, 32'h12345678);
        #1;
        check({tag, " stall"}, o_stall, 0);
        check({tag, " req"}, o_mem_req, 0);
        next_cycle();
        drive_idle();
        #1;
        check({tag, " valid"}, o_valid, 1);
        check({tag, " mis"}, o_misaligned, exp_mis);
        check({tag, " rdata"}, o_ReadData, 0);
        check({tag, " fault"}, o_fault, 0);
        check({tag, " req_after"}, o_mem_req, 0);
    endtask

    initial begin
        i_rst       = 1'b1;
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'd0;
        drive_idle();

        // Reset state
        repeat (2) @(posedge i_clk);
        #3;
        check("rst valid", o_valid, 0);
        check("rst stall", o_stall, 0);
        check("rst req", o_mem_req, 0);
        check("rst we", o_mem_we, 0);
        check("rst addr", o_mem_addr, 0);
        check("rst be", o_mem_be, 0);
        check("rst wdata", o_mem_wdata, 0);
        check("rst rdata", o_ReadData, 0);
        check("rst mis", o_misaligned, 0);
        check("rst fault", o_fault, 0);
        i_rst = 1'b0;
        next_cycle();

        // Loads
        do_access("LW100", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF,
                  32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
        do_access("LB103", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01,
                  32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
        do_access("LBU103", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01,
                  32'h100, 4'b1000, 32'h0, 32'h00000080);
        do_access("LH102", 1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF7F01,
                  32'h100, 4'b1100, 32'h0, 32'hFFFF80FF);

        // Rejected accesses: ReadData drops from the previous 0xFFFF80FF to 0
        quick_op("LW102_mis", 1, 0, 3'b010, 32'h102, 1);
        quick_op("SH101_mis", 0, 1, 3'b001, 32'h101, 1);
        quick_op("LD011_ill", 1, 0, 3'b011, 32'h100, 1);
        quick_op("SBU_ill", 0, 1, 3'b100, 32'h100, 1);
        quick_op("nonmem", 0, 0, 3'b010, 32'h101, 0);

        // Stores (bus read data must not leak into ReadData)
        do_access("SB201", 0, 1, 3'b000, 32'h201, 32'h123456AB, 32'hFFFFFFFF,
                  32'h200, 4'b0010, 32'hABABABAB, 32'h0);
        do_access("SH202", 0, 1, 3'b001, 32'h202, 32'h123456AB, 32'hFFFFFFFF,
                  32'h200, 4'b1100, 32'h56AB56AB, 32'h0);
        do_access("LHU102", 1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF7F01,
                  32'h100, 4'b1100, 32'h0, 32'h000080FF);
        do_access("LW104", 1, 0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D,
                  32'h104, 4'b1111, 32'h0, 32'hCAFEF00D);

        // Timeout: ack withheld
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        #1;
        check("to accept_stall", o_stall, 1);
        req_cycles = 0;
        seen_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge i_clk);
            #3;
            if (o_valid) begin
                seen_valid = 1'b1;
                break;
            end
            if (o_mem_req) req_cycles++;
        end
        check("to seen_valid", seen_valid, 1);
        check("to req_cycles", req_cycles, 15);
        check("to fault", o_fault, 1);
        check("to rdata", o_ReadData, 0);
        check("to mis", o_misaligned, 0);
        check("to stall", o_stall, 0);
        check("to req", o_mem_req, 0);
        next_cycle();
        drive_idle();
        i_mem_ack   = 1'b1;   // late ack while idle
        i_mem_rdata = 32'h55555555;
        #1;
        check("late_ack valid", o_valid, 0);
        check("late_ack req", o_mem_req, 0);
        next_cycle();
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'd0;
        #1;
        check("late_ack valid2", o_valid, 0);
        check("late_ack rdata_held", o_ReadData, 0);
        check("late_ack fault_held", o_fault, 1);

        // Reset in the middle of a BUSY wait
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h108, 32'h0);
        #1;
        check("rb accept_stall", o_stall, 1);
        next_cycle();
        #1;
        check("rb busy_req", o_mem_req, 1);
        next_cycle();
        next_cycle();
        i_rst = 1'b1;
        drive_idle();
        @(posedge i_clk);
        #3;
        check("rb req", o_mem_req, 0);
        check("rb valid", o_valid, 0);
        check("rb stall", o_stall, 0);
        check("rb fault", o_fault, 0);
        check("rb addr", o_mem_addr, 0);
        check("rb be", o_mem_be, 0);
        i_rst = 1'b0;
        do_access("LW10C", 1, 0, 3'b010, 32'h10C, 32'h0, 32'h12345678,
                  32'h10C, 4'b1111, 32'h0, 32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
